// File: rtl/symbol_pkg.sv
// Shared types and the bit-to-symbol mapping rule used by the serializer
// and by any future slicer working on the same symbol alphabet.
package symbol_pkg;

    typedef enum logic {
        MODE_BIPOLAR,
        MODE_UNIPOLAR
    } sym_mode_e;

    typedef enum logic {
        ORDER_MSB_FIRST,
        ORDER_LSB_FIRST
    } bit_order_e;

    localparam int DEF_SYM_W = 16;
    localparam logic signed [DEF_SYM_W-1:0] DEF_AMP = 16'sh4000;

    // Mapping is done at a generous fixed width; callers truncate to their
    // own SYM_W, which is lossless because |amp| < 2^(SYM_W-1).
    localparam int MAP_W = 32;

    function automatic logic signed [MAP_W-1:0] map_bit(
        input logic                    b,
        input sym_mode_e               mode,
        input logic signed [MAP_W-1:0] amp
    );
        if (b) begin
            return amp;
        end else if (mode == MODE_BIPOLAR) begin
            return -amp;
        end else begin
            return '0;
        end
    endfunction

endpackage

// File: rtl/symbol_map.sv
// Combinational bit-to-symbol mapper: +AMP for a one, -AMP or 0 for a zero.
module symbol_map
    import symbol_pkg::*;
#(
    parameter int                       SYM_W = DEF_SYM_W,
    parameter logic signed [SYM_W-1:0]  AMP   = DEF_AMP,
    parameter sym_mode_e                MODE  = MODE_BIPOLAR
) (
    input  logic                    bit_in,
    output logic signed [SYM_W-1:0] sym
);

    assign sym = SYM_W'(map_bit(bit_in, MODE, MAP_W'(AMP)));

endmodule

// File: rtl/bit_symbol_serializer.sv
// Serializes DATA_W-bit words into one signed symbol per cycle through a
// hold register feeding a shift register, with message framing and a counter.
module bit_symbol_serializer
    import symbol_pkg::*;
#(
    parameter int                       DATA_W    = 8,
    parameter int                       SYM_W     = DEF_SYM_W,
    parameter logic signed [SYM_W-1:0]  AMP       = DEF_AMP,
    parameter bit                       BIPOLAR   = 1'b1,
    parameter bit                       LSB_FIRST = 1'b0,
    parameter int                       CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [SYM_W-1:0] sym_data,
    output logic                    sym_last,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        sym_count
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam sym_mode_e  MODE  = BIPOLAR   ? MODE_BIPOLAR    : MODE_UNIPOLAR;
    localparam bit_order_e ORDER = LSB_FIRST ? ORDER_LSB_FIRST : ORDER_MSB_FIRST;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    state_e              state;
    logic [DATA_W-1:0]   hold_data;
    logic                hold_last;
    logic                hold_v;
    logic [DATA_W-1:0]   sh_data;
    logic                sh_last;
    logic [IDX_W-1:0]    idx;

    logic                in_fire;
    logic                sym_fire;
    logic                at_last;
    logic                load_shift;
    logic [IDX_W-1:0]    sel_idx;
    logic                cur_bit;
    logic signed [SYM_W-1:0] mapped;

    assign in_ready   = !hold_v;
    assign in_fire    = in_valid && in_ready;
    assign sym_valid  = (state == ST_SHIFT);
    assign sym_fire   = sym_valid && sym_ready;
    assign at_last    = (idx == LAST_IDX);
    // The hold register drains either into an idle shifter or, without a
    // bubble, on the final symbol transfer of the current word.
    assign load_shift = hold_v && ((state == ST_IDLE) || (sym_fire && at_last));

    assign sel_idx = (ORDER == ORDER_LSB_FIRST) ? idx : (LAST_IDX - idx);
    assign cur_bit = sh_data[sel_idx];

    symbol_map #(
        .SYM_W (SYM_W),
        .AMP   (AMP),
        .MODE  (MODE)
    ) u_map (
        .bit_in (cur_bit),
        .sym    (mapped)
    );

    assign sym_data = sym_valid ? mapped : '0;
    assign sym_last = sym_valid && sh_last && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold_data <= '0;
            hold_last <= 1'b0;
            hold_v    <= 1'b0;
            sh_data   <= '0;
            sh_last   <= 1'b0;
            idx       <= '0;
            sym_count <= '0;
        end else begin
            if (in_fire) begin
                hold_data <= in_data;
                hold_last <= in_last;
            end
            hold_v <= in_fire || (hold_v && !load_shift);

            case (state)
                ST_IDLE: begin
                    if (hold_v) begin
                        sh_data <= hold_data;
                        sh_last <= hold_last;
                        idx     <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sym_fire) begin
                        if (!at_last) begin
                            idx <= idx + 1'b1;
                        end else if (hold_v) begin
                            sh_data <= hold_data;
                            sh_last <= hold_last;
                            idx     <= '0;
                        end else begin
                            idx   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (cnt_clr) begin
                sym_count <= '0;
            end else if (sym_fire) begin
                sym_count <= sym_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_symbol_serializer.sv
// Directed bench: three serializer variants (MSB/bipolar, LSB/unipolar,
// 4-bit counter) share one input stream and are checked against hand values.
module tb_bit_symbol_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        sym_ready = 1'b1;
    logic        cnt_clr = 1'b0;
    logic        cnt_clr_c = 1'b0;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic [15:0] sym_data_a, sym_data_b, sym_data_c;
    logic        sym_last_a, sym_last_b, sym_last_c;
    logic        sym_valid_a, sym_valid_b, sym_valid_c;
    logic [15:0] sym_count_a, sym_count_b;
    logic [3:0]  sym_count_c;

    always #5 clk = ~clk;

    bit_symbol_serializer #(.DATA_W(8), .SYM_W(16), .AMP(16'sh4000),
                            .BIPOLAR(1'b1), .LSB_FIRST(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready_a), .sym_data(sym_data_a),
        .sym_last(sym_last_a), .sym_valid(sym_valid_a), .sym_ready(sym_ready),
        .cnt_clr(cnt_clr), .sym_count(sym_count_a)
    );

    bit_symbol_serializer #(.DATA_W(8), .SYM_W(16), .AMP(16'sh4000),
                            .BIPOLAR(1'b0), .LSB_FIRST(1'b1), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready_b), .sym_data(sym_data_b),
        .sym_last(sym_last_b), .sym_valid(sym_valid_b), .sym_ready(sym_ready),
        .cnt_clr(cnt_clr), .sym_count(sym_count_b)
    );

    bit_symbol_serializer #(.DATA_W(8), .SYM_W(16), .AMP(16'sh4000),
                            .BIPOLAR(1'b1), .LSB_FIRST(1'b0), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready_c), .sym_data(sym_data_c),
        .sym_last(sym_last_c), .sym_valid(sym_valid_c), .sym_ready(sym_ready),
        .cnt_clr(cnt_clr_c), .sym_count(sym_count_c)
    );

    int checks = 0;
    int errors = 0;

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_a(input logic [7:0] w, input int i);
        return w[7-i] ? 16'h4000 : 16'hC000;
    endfunction

    function automatic logic [15:0] exp_b(input logic [7:0] w, input int i);
        return w[i] ? 16'h4000 : 16'h0000;
    endfunction

    typedef struct {
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_last;
    } vec_t;

    vec_t vec[8];

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        sym_ready = 1'b1;
        cnt_clr = 1'b0;
        cnt_clr_c = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one word and returns just after the edge that accepted it.
    task automatic send_word(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a) check_bit("send_timeout", in_ready_a, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!sym_valid_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!sym_valid_a) check_bit(name, sym_valid_a, 1'b1);
    endtask

    // Stall monitor: while enabled, collects transferred symbols and checks
    // that a stalled symbol is held unchanged on the next cycle.
    logic        mon_en = 1'b0;
    logic        stalled = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int          stall_cnt = 0;
    logic [16:0] got_q[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (stalled) begin
                check_bit("stall_valid", sym_valid_a, 1'b1);
                check16("stall_data", sym_data_a, prev_data);
                check_bit("stall_last", sym_last_a, prev_last);
                stall_cnt++;
            end
            if (sym_valid_a && sym_ready) got_q.push_back({sym_last_a, sym_data_a});
            stalled   <= sym_valid_a && !sym_ready;
            prev_data <= sym_data_a;
            prev_last <= sym_last_a;
        end else begin
            stalled <= 1'b0;
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    logic [7:0]  msg4[4];
    logic [16:0] exp_q[$];

    initial begin
        vec[0] = '{16'hC000, 16'h4000, 1'b0};
        vec[1] = '{16'h4000, 16'h0000, 1'b0};
        vec[2] = '{16'hC000, 16'h0000, 1'b0};
        vec[3] = '{16'hC000, 16'h0000, 1'b0};
        vec[4] = '{16'hC000, 16'h0000, 1'b0};
        vec[5] = '{16'hC000, 16'h0000, 1'b0};
        vec[6] = '{16'hC000, 16'h4000, 1'b0};
        vec[7] = '{16'h4000, 16'h0000, 1'b1};

        // Reset state
        do_reset();
        @(negedge clk);
        check_bit("rst_in_ready", in_ready_a, 1'b1);
        check_bit("rst_sym_valid", sym_valid_a, 1'b0);
        check_bit("rst_sym_last", sym_last_a, 1'b0);
        check16("rst_sym_data", sym_data_a, 16'h0000);
        check16("rst_count_a", sym_count_a, 16'd0);
        check16("rst_count_c", 16'(sym_count_c), 16'd0);

        // 'A' with last: table of per-cycle symbols for both bit orders/modes
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h41;
        in_last  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_bit("a_latency_valid", sym_valid_a, 1'b0);
        check_bit("a_hold_full", in_ready_a, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check_bit("a_valid", sym_valid_a, 1'b1);
            check16("a_data_msb_bip", sym_data_a, vec[i].exp_a);
            check16("a_data_lsb_uni", sym_data_b, vec[i].exp_b);
            check_bit("a_last_a", sym_last_a, vec[i].exp_last);
            check_bit("a_last_b", sym_last_b, vec[i].exp_last);
            @(negedge clk);
        end
        check_bit("a_idle_after", sym_valid_a, 1'b0);
        check16("a_count_a", sym_count_a, 16'd8);
        check16("a_count_b", sym_count_b, 16'd8);
        check16("a_count_c", 16'(sym_count_c), 16'd8);

        // "Hi" back to back: 16 symbols with no bubble
        do_reset();
        fork
            begin
                send_word(8'h48, 1'b0);
                @(negedge clk);
                check_bit("hi_hold_full", in_ready_a, 1'b0);
                @(posedge clk);
                #1;
                send_word(8'h69, 1'b1);
            end
            begin
                logic [7:0] w;
                wait_valid("hi_first_valid");
                for (int k = 0; k < 16; k++) begin
                    w = (k < 8) ? 8'h48 : 8'h69;
                    check_bit("hi_valid", sym_valid_a, 1'b1);
                    check16("hi_data_a", sym_data_a, exp_a(w, k % 8));
                    check16("hi_data_b", sym_data_b, exp_b(w, k % 8));
                    check_bit("hi_last", sym_last_a, k == 15);
                    @(negedge clk);
                end
                check_bit("hi_idle_after", sym_valid_a, 1'b0);
                check16("hi_count", sym_count_a, 16'd16);
            end
        join

        // 4-word message with random downstream stalls
        do_reset();
        msg4[0] = 8'h54;
        msg4[1] = 8'h65;
        msg4[2] = 8'h73;
        msg4[3] = 8'h74;
        exp_q.delete();
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back({(w == 3) && (i == 7), exp_a(msg4[w], i)});
            end
        end
        got_q.delete();
        stall_cnt = 0;
        mon_en = 1'b1;
        fork
            begin
                for (int w = 0; w < 4; w++) send_word(msg4[w], w == 3);
            end
            begin
                int n;
                n = 0;
                while (got_q.size() < 32 && n < 2000) begin
                    @(posedge clk);
                    #1 sym_ready = 1'($urandom_range(0, 1));
                    n++;
                end
                sym_ready = 1'b1;
                mon_en = 1'b0;
            end
        join
        check16("stall_sym_total", 16'(got_q.size()), 16'd32);
        for (int i = 0; i < 32; i++) begin
            if (i < got_q.size()) check16("stall_seq_data", got_q[i][15:0], exp_q[i][15:0]);
            if (i < got_q.size()) check_bit("stall_seq_last", got_q[i][16], exp_q[i][16]);
        end
        check_bit("stall_seen", stall_cnt != 0, 1'b1);
        @(negedge clk);
        check16("stall_count", sym_count_a, 16'd32);
        check_bit("stall_idle_after", sym_valid_a, 1'b0);

        // Reset in the middle of the second word
        do_reset();
        send_word(8'h55, 1'b0);
        send_word(8'hAA, 1'b1);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (sym_count_a != 16'd10 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check16("mid_reach_count", sym_count_a, 16'd10);
        check_bit("mid_valid_before", sym_valid_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("mid_rst_valid", sym_valid_a, 1'b0);
        check_bit("mid_rst_ready", in_ready_a, 1'b1);
        check16("mid_rst_count", sym_count_a, 16'd0);
        check16("mid_rst_data", sym_data_a, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bit("mid_no_stale_symbol", sym_valid_a, 1'b0);
        end
        @(posedge clk);
        #1;
        send_word(8'hFF, 1'b1);
        wait_valid("ff_first_valid");
        for (int i = 0; i < 8; i++) begin
            check_bit("ff_valid", sym_valid_a, 1'b1);
            check16("ff_data_a", sym_data_a, 16'h4000);
            check16("ff_data_b", sym_data_b, 16'h4000);
            check_bit("ff_last", sym_last_a, i == 7);
            @(negedge clk);
        end
        check16("ff_count", sym_count_a, 16'd8);

        // 4-bit counter: clear on the 10th transfer, then wrap 15 -> 0
        do_reset();
        sym_ready = 1'b0;
        fork
            begin
                send_word(8'h0F, 1'b0);
                send_word(8'hF0, 1'b0);
                send_word(8'h3C, 1'b0);
                send_word(8'hC3, 1'b1);
            end
            begin
                wait_valid("cnt_first_valid");
                for (int k = 1; k <= 26; k++) begin
                    check_bit("cnt_valid", sym_valid_c, 1'b1);
                    sym_ready = 1'b1;
                    cnt_clr_c = (k == 10);
                    @(posedge clk);
                    #1 cnt_clr_c = 1'b0;
                    if (k == 9)  check16("cnt_before_clr", 16'(sym_count_c), 16'd9);
                    if (k == 10) check16("cnt_clr_wins", 16'(sym_count_c), 16'd0);
                    if (k == 17) check16("cnt_after_17", 16'(sym_count_c), 16'd7);
                    if (k == 25) check16("cnt_at_15", 16'(sym_count_c), 16'd15);
                    if (k == 26) check16("cnt_wrap", 16'(sym_count_c), 16'd0);
                    @(negedge clk);
                end
                check16("cnt_wide_unaffected", sym_count_a, 16'd26);
            end
        join
        begin
            int n;
            n = 0;
            while (sym_valid_a && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check_bit("cnt_drained", sym_valid_a, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
